// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// fetch_sequencer_if
// Instruction-memory request/response channel between fetch and imem.
// Revision: 1.0
// ============================================================================
interface fetch_sequencer_if #(
  parameter int PC_WIDTH   = 32,
  parameter int INSN_WIDTH = 32
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [PC_WIDTH-1:0]   imem_req_addr;
  logic                  imem_resp_valid;
  logic [INSN_WIDTH-1:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// fetch_sequencer
// Owns the fetch PC, issues imem requests and buffers responses for decode.
// Revision: 1.0
// ============================================================================
module fetch_sequencer #(
  parameter int                  PC_WIDTH        = 32,
  parameter int                  INSN_WIDTH      = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC        = '0,
  parameter int                  MAX_OUTSTANDING = 2
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  stall,
  input  wire logic                  redirect_valid,
  input  wire logic [PC_WIDTH-1:0]   redirect_pc,
  input  wire logic                  btb_hit,
  input  wire logic [PC_WIDTH-1:0]   btb_predicted_pc,
  output logic      [PC_WIDTH-1:0]   pc,
  fetch_sequencer_if.master          imem,
  output logic                       insn_valid,
  output logic      [INSN_WIDTH-1:0] insn,
  output logic      [PC_WIDTH-1:0]   insn_pc,
  output logic                       insn_pred_taken,
  output logic      [PC_WIDTH-1:0]   insn_pred_pc
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] c_lastPtr = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] c_depth   = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == c_lastPtr) ? '0 : p + PTR_W'(1);
  endfunction

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [CNT_W-1:0]    r_inflight;
  logic [CNT_W-1:0]    r_occ;
  logic [PTR_W-1:0]    r_tagWr;
  logic [PTR_W-1:0]    r_tagRd;
  logic [PTR_W-1:0]    r_rspWr;
  logic [PTR_W-1:0]    r_rspRd;

  // Tag FIFO holds fetch-time context until the matching response returns.
  logic [PC_WIDTH-1:0]   r_tagPc     [MAX_OUTSTANDING];
  logic                  r_tagTaken  [MAX_OUTSTANDING];
  logic [PC_WIDTH-1:0]   r_tagPredPc [MAX_OUTSTANDING];
  logic [INSN_WIDTH-1:0] r_rspData   [MAX_OUTSTANDING];
  logic [PC_WIDTH-1:0]   r_rspPc     [MAX_OUTSTANDING];
  logic                  r_rspTaken  [MAX_OUTSTANDING];
  logic [PC_WIDTH-1:0]   r_rspPredPc [MAX_OUTSTANDING];

  logic                w_redirect;
  logic                w_credit;
  logic                w_reqValid;
  logic                w_fire;
  logic [PC_WIDTH-1:0] w_nextPc;
  logic                w_respIn;
  logic                w_respKeep;
  logic                w_haveInsn;
  logic                w_pop;

  assign w_redirect = redirect_valid && (r_state != S_BOOT);
  // Buffered responses consume credit too, so a stalled decode throttles fetch.
  assign w_credit   = ({1'b0, r_inflight} + {1'b0, r_occ}) < {1'b0, c_depth};
  assign w_reqValid = (r_state == S_FETCH) && !redirect_valid && w_credit;
  assign w_fire     = w_reqValid && imem.imem_req_ready;
  assign w_nextPc   = btb_hit ? btb_predicted_pc : r_pc + PC_WIDTH'(4);
  assign w_respIn   = imem.imem_resp_valid && (r_inflight != '0);
  assign w_respKeep = w_respIn && (r_state == S_FETCH) && !redirect_valid;
  assign w_haveInsn = (r_occ != '0);
  assign w_pop      = w_haveInsn && !stall && !w_redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_occ      <= '0;
      r_tagWr    <= '0;
      r_tagRd    <= '0;
      r_rspWr    <= '0;
      r_rspRd    <= '0;
    end else begin
      case (r_state)
        S_BOOT:  r_state <= S_FETCH;
        S_FETCH: if (redirect_valid && (r_inflight != '0)) r_state <= S_FLUSH;
        S_FLUSH: if ((r_inflight == '0) && !redirect_valid) r_state <= S_FETCH;
        default: r_state <= S_BOOT;
      endcase

      if (w_redirect) begin
        r_pc <= redirect_pc;
      end else if (w_fire) begin
        r_pc <= w_nextPc;
      end

      if (w_fire)   r_tagWr <= bump(r_tagWr);
      if (w_respIn) r_tagRd <= bump(r_tagRd);
      case ({w_fire, w_respIn})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase

      if (w_redirect) begin
        r_rspWr <= '0;
        r_rspRd <= '0;
        r_occ   <= '0;
      end else begin
        if (w_respKeep) r_rspWr <= bump(r_rspWr);
        if (w_pop)      r_rspRd <= bump(r_rspRd);
        case ({w_respKeep, w_pop})
          2'b10:   r_occ <= r_occ + CNT_W'(1);
          2'b01:   r_occ <= r_occ - CNT_W'(1);
          default: r_occ <= r_occ;
        endcase
      end
    end
  end

  // Storage needs no reset: every read is qualified by the occupancy counters.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      r_tagPc[r_tagWr]     <= r_pc;
      r_tagTaken[r_tagWr]  <= btb_hit;
      r_tagPredPc[r_tagWr] <= w_nextPc;
    end
    if (w_respKeep) begin
      r_rspData[r_rspWr]   <= imem.imem_resp_data;
      r_rspPc[r_rspWr]     <= r_tagPc[r_tagRd];
      r_rspTaken[r_rspWr]  <= r_tagTaken[r_tagRd];
      r_rspPredPc[r_rspWr] <= r_tagPredPc[r_tagRd];
    end
  end

  assign pc                  = r_pc;
  assign imem.imem_req_valid = w_reqValid;
  assign imem.imem_req_addr  = r_pc;
  assign insn_valid          = w_haveInsn;
  assign insn                = w_haveInsn ? r_rspData[r_rspRd]   : '0;
  assign insn_pc             = w_haveInsn ? r_rspPc[r_rspRd]     : '0;
  assign insn_pred_taken     = w_haveInsn ? r_rspTaken[r_rspRd]  : 1'b0;
  assign insn_pred_pc        = w_haveInsn ? r_rspPredPc[r_rspRd] : '0;

  a_respWithoutRequest: assert property (@(posedge clk) disable iff (!rst)
    !(imem.imem_resp_valid && (r_inflight == '0)));
  a_respOverflow: assert property (@(posedge clk) disable iff (!rst)
    !(w_respKeep && (r_occ == c_depth)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fetch_sequencer
// Directed bench for fetch_sequencer with a fixed-latency in-order imem model.
// Revision: 1.0
// ============================================================================
module tb_fetch_sequencer;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        taken;
    logic [31:0] pred;
  } insnRec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectPc = '0;
  logic        btbArm = 1'b0;
  logic [31:0] btbSrc = '0;
  logic [31:0] btbTarget = '0;
  logic        btbHit;
  logic [31:0] pc;
  logic        reqReady = 1'b0;
  logic        insnValid;
  logic [31:0] insn;
  logic [31:0] insnPc;
  logic        insnPredTaken;
  logic [31:0] insnPredPc;
  int          memLat = 1;
  int          nChecks = 0;
  int          nPass = 0;

  logic [31:0] fireQ[$];
  insnRec_t    insnQ[$];
  logic        mVld [8];
  logic [31:0] mAddr [8];

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  fetch_sequencer_if #(.PC_WIDTH(32), .INSN_WIDTH(32)) imemIf();

  fetch_sequencer #(
    .PC_WIDTH(32), .INSN_WIDTH(32), .RESET_PC(32'h0), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirectValid), .redirect_pc(redirectPc),
    .btb_hit(btbHit), .btb_predicted_pc(btbTarget), .pc(pc),
    .imem(imemIf),
    .insn_valid(insnValid), .insn(insn), .insn_pc(insnPc),
    .insn_pred_taken(insnPredTaken), .insn_pred_pc(insnPredPc)
  );

  always #5 clk = ~clk;

  assign btbHit                 = btbArm && (pc == btbSrc);
  assign imemIf.imem_req_ready  = reqReady;
  assign imemIf.imem_resp_valid = mVld[memLat-1];
  assign imemIf.imem_resp_data  = memData(mAddr[memLat-1]);

  // In-order memory: a request accepted at edge N answers during cycle N+memLat.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        mVld[i]  <= 1'b0;
        mAddr[i] <= '0;
      end
    end else begin
      mVld[0]  <= imemIf.imem_req_valid && imemIf.imem_req_ready;
      mAddr[0] <= imemIf.imem_req_addr;
      for (int i = 1; i < 8; i++) begin
        mVld[i]  <= mVld[i-1];
        mAddr[i] <= mAddr[i-1];
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      if (imemIf.imem_req_valid && imemIf.imem_req_ready)
        fireQ.push_back(imemIf.imem_req_addr);
      if (insnValid && !stall && !redirectValid)
        insnQ.push_back('{insnPc, insn, insnPredTaken, insnPredPc});
    end
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else nPass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int cycles);
    reqReady = 1'b0;
    repeat (cycles) step();
  endtask

  task automatic runUntilFires(input int n, input int budget);
    reqReady = 1'b1;
    for (int i = 0; i < budget && fireQ.size() < n; i++) step();
    reqReady = 1'b0;
    #1;
    checkVal("fireCount", fireQ.size(), n);
  endtask

  task automatic doRedirect(input logic [31:0] target);
    redirectValid = 1'b1;
    redirectPc    = target;
    step();
    redirectValid = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] fireAt(input int i);
    return (fireQ.size() > i) ? fireQ[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic insnRec_t insnAt(input int i);
    insnRec_t none;
    none = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'bx, 32'hDEAD_BEEF};
    return (insnQ.size() > i) ? insnQ[i] : none;
  endfunction

  task automatic clearQ();
    fireQ.delete();
    insnQ.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    insnRec_t r;
    #2 rst = 1'b0;
    repeat (3) step();
    checkVal("rst_pc", pc, 32'h0);
    checkVal("rst_reqValid", imemIf.imem_req_valid, 1'b0);
    checkVal("rst_insnValid", insnValid, 1'b0);
    rst = 1'b1;

    // Sequential fetch from reset.
    runUntilFires(3, 20);
    drain(6);
    checkVal("seq_addr0", fireAt(0), 32'h0);
    checkVal("seq_addr1", fireAt(1), 32'h4);
    checkVal("seq_addr2", fireAt(2), 32'h8);
    checkVal("seq_nInsn", insnQ.size(), 3);
    for (int i = 0; i < 3; i++) begin
      r = insnAt(i);
      checkVal($sformatf("seq_pc%0d", i), r.pc, 32'(4 * i));
      checkVal($sformatf("seq_data%0d", i), r.data, memData(32'(4 * i)));
    end

    // BTB prediction at 0x8.
    clearQ();
    doRedirect(32'h8);
    checkVal("btb_pcAfterRedirect", pc, 32'h8);
    btbArm = 1'b1; btbSrc = 32'h8; btbTarget = 32'h100;
    runUntilFires(2, 20);
    btbArm = 1'b0;
    drain(6);
    checkVal("btb_addr0", fireAt(0), 32'h8);
    checkVal("btb_addr1", fireAt(1), 32'h100);
    r = insnAt(0);
    checkVal("btb_pc0", r.pc, 32'h8);
    checkVal("btb_taken0", r.taken, 1'b1);
    checkVal("btb_pred0", r.pred, 32'h100);
    r = insnAt(1);
    checkVal("btb_pc1", r.pc, 32'h100);
    checkVal("btb_taken1", r.taken, 1'b0);
    checkVal("btb_pred1", r.pred, 32'h104);

    // Decode stall throttles fetch to the credit limit.
    clearQ();
    stall = 1'b1; reqReady = 1'b1;
    repeat (2) step();
    checkVal("stall_insnPcEarly", insnPc, 32'h104);
    checkVal("stall_insnEarly", insn, memData(32'h104));
    repeat (3) step();
    checkVal("stall_fires", fireQ.size(), 2);
    checkVal("stall_reqValid", imemIf.imem_req_valid, 1'b0);
    checkVal("stall_insnValid", insnValid, 1'b1);
    checkVal("stall_insnPcLate", insnPc, 32'h104);
    checkVal("stall_insnLate", insn, memData(32'h104));
    checkVal("stall_noPop", insnQ.size(), 0);
    reqReady = 1'b0; stall = 1'b0;
    drain(6);
    checkVal("stall_nDrained", insnQ.size(), 2);
    checkVal("stall_drain0", insnAt(0).pc, 32'h104);
    checkVal("stall_drain1", insnAt(1).pc, 32'h108);
    checkVal("stall_data1", insnAt(1).data, memData(32'h108));

    // Redirect with two requests in flight.
    clearQ();
    memLat = 4;
    runUntilFires(2, 10);
    reqReady = 1'b1;
    doRedirect(32'h200);
    checkVal("flush_pc", pc, 32'h200);
    checkVal("flush_reqValid", imemIf.imem_req_valid, 1'b0);
    checkVal("flush_insnValid", insnValid, 1'b0);
    runUntilFires(3, 20);
    drain(8);
    checkVal("flush_nextAddr", fireAt(2), 32'h200);
    checkVal("flush_nInsn", insnQ.size(), 1);
    checkVal("flush_insnPc", insnAt(0).pc, 32'h200);
    checkVal("flush_insnData", insnAt(0).data, memData(32'h200));

    // Back-to-back redirects, second lands in FLUSH.
    clearQ();
    runUntilFires(2, 10);
    doRedirect(32'h300);
    checkVal("b2b_pc1", pc, 32'h300);
    doRedirect(32'h400);
    checkVal("b2b_pc2", pc, 32'h400);
    checkVal("b2b_reqValid", imemIf.imem_req_valid, 1'b0);
    runUntilFires(3, 20);
    drain(8);
    checkVal("b2b_nextAddr", fireAt(2), 32'h400);
    checkVal("b2b_nInsn", insnQ.size(), 1);
    checkVal("b2b_insnPc", insnAt(0).pc, 32'h400);

    // PC wrap, then asynchronous reset mid-stream.
    clearQ();
    memLat = 1;
    doRedirect(32'hFFFF_FFFC);
    runUntilFires(2, 10);
    checkVal("wrap_addr0", fireAt(0), 32'hFFFF_FFFC);
    checkVal("wrap_addr1", fireAt(1), 32'h0);
    reqReady = 1'b1;
    step();
    checkVal("midrst_preInsnValid", insnValid, 1'b1);
    rst = 1'b0;
    #1;
    checkVal("midrst_pc", pc, 32'h0);
    checkVal("midrst_reqValid", imemIf.imem_req_valid, 1'b0);
    checkVal("midrst_insnValid", insnValid, 1'b0);
    checkVal("midrst_insn", insn, 32'h0);
    checkVal("midrst_insnPc", insnPc, 32'h0);
    checkVal("midrst_predTaken", insnPredTaken, 1'b0);
    reqReady = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    clearQ();
    runUntilFires(1, 10);
    checkVal("postrst_addr", fireAt(0), 32'h0);
    drain(4);
    checkVal("postrst_insnPc", insnAt(0).pc, 32'h0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
